rf_write_arbiter: RTL and testbench

Shares the register file's single write port between the writeback stage (primary) and the multi-cycle mul/div unit (secondary). The writeback stage normally wins. Mul/div results queue in a small FIFO and take the port on idle writeback cycles, or by forcing a one-cycle writeback stall once they have waited too long. The block also exports a pending-write bitmap that the hazard unit uses to hold back dependent instructions.

---
 rtl/rf_write_arbiter.sv | 144 ++++++++++++++
 tb/tb_rf_write_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between the writeback
// stage (primary) and a small FIFO of mul/div results (secondary). Queued
// results take idle writeback cycles, or force a one-cycle writeback stall
// once they have waited STARVE_LIMIT cycles. busy_mask flags registers that
// still have a queued mul/div write pending.
// Optional feature macro: RF_ARB_BYPASS_EN. When it is defined, a mul/div
// result skips an empty FIFO and writes in the same cycle if writeback is idle.
module rf_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        wb_stall,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_addr,
  input  logic [31:0] md_data,
  output logic        reg_we,
  output logic [4:0]  reg_a_write,
  output logic [31:0] reg_write,
  output logic [31:0] busy_mask
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

  logic [4:0]       addr_mem_q [DEPTH];
  logic [31:0]      data_mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [STV_W-1:0] starve_q, starve_d;

  logic wb_req;
  logic fifo_empty;
  logic fifo_full;
  logic force_grant;
  logic sec_grant;
  logic bypass;
  logic push;
  logic pop;

  // A write to x0 is no request at all; rst_n gating keeps the port quiet
  // while reset is held even if writeback inputs are toggling.
  assign wb_req      = rst_n && wb_we && (wb_addr != 5'd0);
  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == CNT_FULL);
  assign force_grant = (starve_q == STV_MAX);
  assign sec_grant   = !fifo_empty && (!wb_req || force_grant);
  assign wb_stall    = wb_req && sec_grant;
  assign md_ready    = !fifo_full || sec_grant;
  assign pop         = sec_grant;

`ifdef RF_ARB_BYPASS_EN
  assign bypass = rst_n && fifo_empty && !wb_req && md_valid && (md_addr != 5'd0);
`else
  assign bypass = 1'b0;
`endif

  // Results for x0 complete the handshake but are dropped; bypassed results
  // never occupy a FIFO slot.
  assign push = md_valid && md_ready && (md_addr != 5'd0) && !bypass;

  // Write-port mux: queued result first when granted, then writeback, then bypass.
  always_comb begin
    reg_we      = 1'b0;
    reg_a_write = 5'd0;
    reg_write   = 32'd0;
    if (sec_grant) begin
      reg_we      = 1'b1;
      reg_a_write = addr_mem_q[rd_ptr_q];
      reg_write   = data_mem_q[rd_ptr_q];
    end else if (wb_req) begin
      reg_we      = 1'b1;
      reg_a_write = wb_addr;
      reg_write   = wb_data;
    end else if (bypass) begin
      reg_we      = 1'b1;
      reg_a_write = md_addr;
      reg_write   = md_data;
    end
  end

  // Pending-write bitmap: one-hot of every valid entry, walked from the head.
  always_comb begin
    busy_mask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_q) begin
        busy_mask[addr_mem_q[rd_ptr_q + PTR_W'(i)]] = 1'b1;
      end
    end
    busy_mask[0] = 1'b0;
  end

  // Next-state for pointers, occupancy and the starvation counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    starve_d = starve_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (sec_grant || fifo_empty) begin
      starve_d = '0;
    end else if (starve_q != STV_MAX) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  // Control state; reset discards anything queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  // FIFO storage; validity comes from count_q, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= md_addr;
      data_mem_q[wr_ptr_q] <= md_data;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed scenarios for the write-port arbiter plus a
// randomized run compared cycle by cycle against a queue-based reference.
// Works with or without RF_ARB_BYPASS_EN defined.
module tb_rf_write_arbiter;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 3;
`ifdef RF_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        wb_stall;
  logic        md_valid = 1'b0;
  logic        md_ready;
  logic [4:0]  md_addr = '0;
  logic [31:0] md_data = '0;
  logic        reg_we;
  logic [4:0]  reg_a_write;
  logic [31:0] reg_write;
  logic [31:0] busy_mask;

  int checks   = 0;
  int failures = 0;

  // Reference model: queued results in arrival order plus a wait counter.
  logic [4:0]  mq_a [$];
  logic [31:0] mq_d [$];
  int          mstarve = 0;

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(wb_stall),
    .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr), .md_data(md_data),
    .reg_we(reg_we), .reg_a_write(reg_a_write), .reg_write(reg_write),
    .busy_mask(busy_mask)
  );

  // 10-unit clock; inputs change on the falling edge and are sampled 1 unit later.
  always #5 clk = ~clk;

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    foreach (mq_a[i]) m[mq_a[i]] = 1'b1;
    return m;
  endfunction

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] mdd);
    @(negedge clk);
    wb_we = we; wb_addr = wa; wb_data = wd;
    md_valid = mv; md_addr = ma; md_data = mdd;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    md_valid = 1'b0; md_addr = '0; md_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rst_n = 1'b0;
      wb_we = 1'($urandom); wb_addr = 5'($urandom); wb_data = $urandom;
      md_valid = 1'($urandom); md_addr = 5'($urandom); md_data = $urandom;
      #1;
      if (reg_we !== 1'b0) begin failures++; $display("[TB] FAIL rst_reg_we actual=%0b expected=0", reg_we); end checks++;
      if (wb_stall !== 1'b0) begin failures++; $display("[TB] FAIL rst_wb_stall actual=%0b expected=0", wb_stall); end checks++;
      if (md_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_md_ready actual=%0b expected=1", md_ready); end checks++;
      if (busy_mask !== 32'd0) begin failures++; $display("[TB] FAIL rst_busy_mask actual=%h expected=0", busy_mask); end checks++;
      if (reg_a_write !== 5'd0 || reg_write !== 32'd0) begin failures++; $display("[TB] FAIL rst_port actual=%0d/%h expected=0/0", reg_a_write, reg_write); end checks++;
    end
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      if (reg_we !== 1'b0) begin failures++; $display("[TB] FAIL idle_reg_we actual=%0b expected=0", reg_we); end checks++;
    end
  endtask

  task automatic test_lone_md();
    apply_reset();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h0000_1234);
    if (reg_we !== BYP) begin failures++; $display("[TB] FAIL lone_c0_we actual=%0b expected=%0b", reg_we, BYP); end checks++;
    if (busy_mask !== 32'd0) begin failures++; $display("[TB] FAIL lone_c0_mask actual=%h expected=0", busy_mask); end checks++;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    if (reg_we !== !BYP) begin failures++; $display("[TB] FAIL lone_c1_we actual=%0b expected=%0b", reg_we, !BYP); end checks++;
    if (!BYP && (reg_a_write !== 5'd5 || reg_write !== 32'h0000_1234)) begin failures++; $display("[TB] FAIL lone_c1_port actual=%0d/%h expected=5/00001234", reg_a_write, reg_write); end checks++;
    if (busy_mask !== (BYP ? 32'd0 : 32'h20)) begin failures++; $display("[TB] FAIL lone_c1_mask actual=%h expected=%h", busy_mask, BYP ? 32'd0 : 32'h20); end checks++;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    if (reg_we !== 1'b0 || busy_mask !== 32'd0) begin failures++; $display("[TB] FAIL lone_c2 actual_we=%0b actual_mask=%h expected=0/0", reg_we, busy_mask); end checks++;
  endtask

  task automatic test_bypass();
    apply_reset();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h55);
    if (reg_we !== BYP) begin failures++; $display("[TB] FAIL byp_c0_we actual=%0b expected=%0b", reg_we, BYP); end checks++;
    if (BYP && (reg_a_write !== 5'd9 || reg_write !== 32'h55)) begin failures++; $display("[TB] FAIL byp_c0_port actual=%0d/%h expected=9/55", reg_a_write, reg_write); end checks++;
    if (busy_mask !== 32'd0) begin failures++; $display("[TB] FAIL byp_c0_mask actual=%h expected=0", busy_mask); end checks++;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    if (reg_we !== !BYP) begin failures++; $display("[TB] FAIL byp_c1_we actual=%0b expected=%0b", reg_we, !BYP); end checks++;
    if (!BYP && (reg_a_write !== 5'd9 || reg_write !== 32'h55)) begin failures++; $display("[TB] FAIL byp_c1_port actual=%0d/%h expected=9/55", reg_a_write, reg_write); end checks++;
  endtask

  task automatic test_starvation();
    logic [4:0]  wa;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic [31:0] em;
    apply_reset();
    for (int k = 0; k < 7; k++) begin
      wa = (k <= 4) ? 5'(k + 1) : 5'(k);
      drive(1'b1, wa, 32'h100 + 32'(wa), (k == 0), 5'd7, 32'hABCD);
      ea = (k == 4) ? 5'd7 : wa;
      ed = (k == 4) ? 32'hABCD : 32'h100 + 32'(wa);
      em = (k >= 1 && k <= 4) ? 32'h80 : 32'd0;
      if (reg_we !== 1'b1 || reg_a_write !== ea || reg_write !== ed) begin failures++; $display("[TB] FAIL starve_port cyc=%0d actual=%0b/%0d/%h expected=1/%0d/%h", k, reg_we, reg_a_write, reg_write, ea, ed); end checks++;
      if (wb_stall !== (k == 4)) begin failures++; $display("[TB] FAIL starve_stall cyc=%0d actual=%0b expected=%0b", k, wb_stall, (k == 4)); end checks++;
      if (busy_mask !== em) begin failures++; $display("[TB] FAIL starve_mask cyc=%0d actual=%h expected=%h", k, busy_mask, em); end checks++;
    end
  endtask

  task automatic test_full_fifo();
    logic [4:0]  wa = '0;
    logic [31:0] wd = '0;
    logic [4:0]  ea;
    logic        estall;
    logic        erdy;
    apply_reset();
    for (int c = 0; c < 14; c++) begin
      if (c != 5 && c != 9) begin wa = 5'(1 + c % 5); wd = 32'h200 + 32'(c); end
      drive((c <= 9), wa, wd, (c <= 4), 5'(10 + c), 32'hA0 + 32'(10 + c));
      case (c)
        4:       ea = 5'd10;
        8:       ea = 5'd11;
        10:      ea = 5'd12;
        11:      ea = 5'd13;
        12:      ea = 5'd14;
        13:      ea = 5'd0;
        default: ea = wa;
      endcase
      estall = (c == 4 || c == 8);
      erdy   = !(c >= 5 && c <= 7);
      if (reg_we !== (c != 13) || reg_a_write !== ea) begin failures++; $display("[TB] FAIL full_port cyc=%0d actual=%0b/%0d expected=%0b/%0d", c, reg_we, reg_a_write, (c != 13), ea); end checks++;
      if (ea >= 5'd10 && reg_write !== 32'hA0 + 32'(ea)) begin failures++; $display("[TB] FAIL full_data cyc=%0d actual=%h expected=%h", c, reg_write, 32'hA0 + 32'(ea)); end checks++;
      if (wb_stall !== estall) begin failures++; $display("[TB] FAIL full_stall cyc=%0d actual=%0b expected=%0b", c, wb_stall, estall); end checks++;
      if (md_ready !== erdy) begin failures++; $display("[TB] FAIL full_ready cyc=%0d actual=%0b expected=%0b", c, md_ready, erdy); end checks++;
      if (c == 5 && busy_mask !== 32'h0000_7800) begin failures++; $display("[TB] FAIL full_mask actual=%h expected=00007800", busy_mask); end checks++;
    end
  endtask

  task automatic test_x0();
    apply_reset();
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd3, 32'h33);
    if (reg_we !== 1'b1 || reg_a_write !== 5'd1 || wb_stall !== 1'b0) begin failures++; $display("[TB] FAIL x0_c0 actual=%0b/%0d/%0b expected=1/1/0", reg_we, reg_a_write, wb_stall); end checks++;
    drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
    if (reg_we !== 1'b1 || reg_a_write !== 5'd3 || reg_write !== 32'h33) begin failures++; $display("[TB] FAIL x0_head actual=%0b/%0d/%h expected=1/3/33", reg_we, reg_a_write, reg_write); end checks++;
    if (wb_stall !== 1'b0) begin failures++; $display("[TB] FAIL x0_nostall actual=%0b expected=0", wb_stall); end checks++;
    drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
    if (reg_we !== 1'b0 || wb_stall !== 1'b0) begin failures++; $display("[TB] FAIL x0_wb_noop actual=%0b/%0b expected=0/0", reg_we, wb_stall); end checks++;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h77);
    if (md_ready !== 1'b1 || reg_we !== 1'b0 || busy_mask !== 32'd0) begin failures++; $display("[TB] FAIL x0_md_push actual=%0b/%0b/%h expected=1/0/0", md_ready, reg_we, busy_mask); end checks++;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    if (reg_we !== 1'b0 || busy_mask !== 32'd0) begin failures++; $display("[TB] FAIL x0_md_after actual=%0b/%h expected=0/0", reg_we, busy_mask); end checks++;
  endtask

  task automatic test_random(input int ncycles);
    logic we = 1'b0; logic [4:0] wa = '0; logic [31:0] wd = '0;
    logic mv = 1'b0; logic [4:0] ma = '0; logic [31:0] mdd = '0;
    logic held_wb = 1'b0, held_md = 1'b0;
    logic m_req, m_ne, m_grant, m_byp, m_ready, m_stall;
    logic e_we; logic [4:0] e_a; logic [31:0] e_d; logic [31:0] e_mask;
    for (int c = 0; c < ncycles; c++) begin
      e_mask = model_mask();
      if (!held_wb) begin
        we = ($urandom_range(0, 99) < 75);
        wa = 5'($urandom); wd = $urandom;
        if (e_mask[wa] || (held_md && wa == ma && wa != 5'd0)) we = 1'b0;
      end
      if (!held_md) begin
        mv = ($urandom_range(0, 99) < 55);
        ma = 5'($urandom); mdd = $urandom;
        if (ma == wa && ma != 5'd0) ma = ma ^ 5'd1;
      end
      drive(we, wa, wd, mv, ma, mdd);
      m_req   = we && (wa != 5'd0);
      m_ne    = (mq_a.size() != 0);
      m_grant = m_ne && (!m_req || (mstarve == STARVE_LIMIT));
      m_byp   = BYP && !m_ne && !m_req && mv && (ma != 5'd0);
      m_ready = (mq_a.size() < DEPTH) || m_grant;
      m_stall = m_req && m_grant;
      if (m_grant) begin e_we = 1'b1; e_a = mq_a[0]; e_d = mq_d[0]; end
      else if (m_req) begin e_we = 1'b1; e_a = wa; e_d = wd; end
      else if (m_byp) begin e_we = 1'b1; e_a = ma; e_d = mdd; end
      else begin e_we = 1'b0; e_a = 5'd0; e_d = 32'd0; end
      if (reg_we !== e_we || reg_a_write !== e_a || reg_write !== e_d) begin failures++; $display("[TB] FAIL rand_port cyc=%0d actual=%0b/%0d/%h expected=%0b/%0d/%h", c, reg_we, reg_a_write, reg_write, e_we, e_a, e_d); end checks++;
      if (wb_stall !== m_stall) begin failures++; $display("[TB] FAIL rand_stall cyc=%0d actual=%0b expected=%0b", c, wb_stall, m_stall); end checks++;
      if (md_ready !== m_ready) begin failures++; $display("[TB] FAIL rand_ready cyc=%0d actual=%0b expected=%0b", c, md_ready, m_ready); end checks++;
      if (busy_mask !== e_mask) begin failures++; $display("[TB] FAIL rand_mask cyc=%0d actual=%h expected=%h", c, busy_mask, e_mask); end checks++;
      if (m_req && busy_mask[wa] !== 1'b0) begin failures++; $display("[TB] FAIL rand_hazard cyc=%0d addr=%0d actual_busy=%0b expected=0", c, wa, busy_mask[wa]); end checks++;
      if (m_grant) begin void'(mq_a.pop_front()); void'(mq_d.pop_front()); end
      if (mv && m_ready && ma != 5'd0 && !m_byp) begin mq_a.push_back(ma); mq_d.push_back(mdd); end
      if (m_grant || !m_ne) mstarve = 0;
      else if (mstarve < STARVE_LIMIT) mstarve++;
      held_wb = m_stall;
      held_md = mv && !m_ready;
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    rst_n = 1'b0;
    wb_we = 1'($urandom); wb_addr = 5'($urandom); wb_data = $urandom;
    md_valid = 1'($urandom); md_addr = 5'($urandom); md_data = $urandom;
    #1;
    if (busy_mask !== 32'd0 || reg_we !== 1'b0 || md_ready !== 1'b1) begin failures++; $display("[TB] FAIL midop_reset actual=%h/%0b/%0b expected=0/0/1", busy_mask, reg_we, md_ready); end checks++;
    mq_a.delete();
    mq_d.delete();
    mstarve = 0;
    @(negedge clk);
    wb_we = 1'b0; md_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  // Scenario sequence, then the single summary line.
  initial begin
    test_reset();
    test_lone_md();
    test_bypass();
    test_starvation();
    test_full_fifo();
    test_x0();
    apply_reset();
    test_random(300);
    test_reset_midop();
    test_random(300);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
